segmented_memory_arbiter: RTL
=============================

// Module: segmented_memory_arbiter
// PURPOSE
// - Shares one SegmentedMemory port between the fetch stage (read-only) and the memory stage (load/store).
// - Sits between the IF/MEM pipeline stages and SegmentedMemory.
// - Sequences each access: grant, hold read/write until valid, return data, pulse ready.
// - Also enforces the segment map and detects memory timeouts.
// PARAMETERS
// - ADDR_W        64   address width
// - DATA_W        64   data width
// - DATA_BASE     512  first data-segment address; below it is instruction segment
// - STARVE_LIMIT  4    consecutive data grants with if_req pending before fetch is forced
// - TIMEOUT       255  BUSY cycles without mem_valid before an error response
// PORTS
// - clk          in   1       clock, rising edge
// - rst          in   1       synchronous active-high reset
// - if_req       in   1       fetch request, held until if_ready
// - if_addr      in   ADDR_W  fetch address
// - if_ready     out  1       one-cycle response pulse
// - if_rdata     out  DATA_W  fetched word, valid with if_ready
// - if_err       out  1       error flag, valid with if_ready
// - dm_req       in   1       data request, held until dm_ready
// - dm_we        in   1       1 = store, 0 = load
// - dm_addr      in   ADDR_W  data address
// - dm_wdata     in   DATA_W  store data
// - dm_ready     out  1       one-cycle response pulse
// - dm_rdata     out  DATA_W  load data, valid with dm_ready (0 for stores)
// - dm_err       out  1       error flag, valid with dm_ready
// - mem_address  out  ADDR_W  to SegmentedMemory.address
// - mem_data_in  out  DATA_W  to SegmentedMemory.data_in
// - mem_read     out  1       to SegmentedMemory.read
// - mem_write    out  1       to SegmentedMemory.write
// - mem_data_out in   DATA_W  from SegmentedMemory.data_out
// - mem_valid    in   1       memory completion, sampled only in BUSY
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; starve and timeout counters 0.
//   Reset mid-transaction drops the transaction: mem_read/mem_write are 0 the next cycle and no ready pulse is issued.
// - All outputs are registered. FSM: IDLE -> BUSY -> RESP -> IDLE.
// - IDLE:
//   - No req: stay in IDLE.
//   - Otherwise pick a winner: dm wins unless if_req && starve_cnt == STARVE_LIMIT.
//   - Latch winner id, addr, we, wdata.
//   - Segment check on the winner:
//     - fetch addr >= DATA_BASE is an error;
//     - store addr < DATA_BASE is an error;
//     - loads to either segment are legal.
//   - Illegal access: go straight to RESP with err=1, rdata=0; no memory access.
//   - Legal access: go to BUSY.
// - BUSY:
//   - mem_read = !we, mem_write = we, mem_address/mem_data_in = latched values.
//   - All four are held constant until mem_valid.
//   - On mem_valid: capture mem_data_out (loads/fetch), go to RESP.
//   - Timeout counter increments each BUSY cycle without mem_valid.
//     At count == TIMEOUT: go to RESP with err=1, rdata=0, and drop mem_read/mem_write.
// - RESP:
//   - Pulse the winner's ready for exactly one cycle with rdata/err; mem_read/mem_write are 0.
//   - Requests are ignored in RESP. Return to IDLE.
//   - Requester must deassert req or present a new request by the following cycle.
// - Latency: legal access with mem_valid on the first BUSY cycle gives req -> ready = 3 cycles; each extra wait cycle adds 1.
// - Starvation counter:
//   - +1 on each data grant while if_req = 1;
//   - cleared on a fetch grant or whenever if_req = 0 in IDLE;
//   - saturates at STARVE_LIMIT.
// - Simultaneous requests: only one is granted per IDLE visit. The loser keeps req high and is granted on a later IDLE visit.
// - A mem_valid seen outside BUSY is ignored.
// - rdata outputs hold their last value between pulses; err outputs are 0 except during their pulse.
// STRUCTURE
// - Package tessia_mem_pkg holds:
//   - arb_state_t enum {IDLE, BUSY, RESP};
//   - requester_t enum {REQ_IF, REQ_DM};
//   - DATA_BASE default constant.
// - Sub-module mem_grant_select holds the winner pick plus the starvation counter: inputs if_req, dm_req, grant-taken strobe; output winner.
// - The FSM, latches and timeout counter stay in the top module.
// TESTING
// - Fetch only:
//   - Stimulus: if_req=1, if_addr=10; memory returns valid 2 cycles after mem_read with 64'hCAFE.
//   - Response: mem_address=10 and mem_read=1 held for 2 cycles; if_ready pulses once with if_rdata=64'hCAFE, if_err=0.
// - Store:
//   - Stimulus: dm_req=1, dm_we=1, dm_addr=512, dm_wdata=64'h123456789ABCDEF0.
//   - Response: mem_write=1 with that data until mem_valid; dm_ready pulses once, dm_err=0, mem_read stays 0.
// - Collision and starvation:
//   - Stimulus: if_req and dm_req both held high.
//   - Response: first 4 grants go to dm, 5th goes to if, then dm again.
// - Segment violations:
//   - Stimulus A: store to addr 100. Stimulus B: fetch from addr 600.
//   - Response: err=1 ready pulse 2 cycles after req; mem_read/mem_write never asserted.
// - Timeout:
//   - Stimulus: mem_valid tied 0, load to addr 700.
//   - Response: dm_ready with dm_err=1, dm_rdata=0 after 255 BUSY cycles.
// - Reset mid-BUSY:
//   - Stimulus: rst pulsed during BUSY.
//   - Response: mem_read=0 the next cycle, no ready pulse, and the next request is served normally.

Source files
------------

// File: rtl/segmented_memory_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package tessia_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

  localparam int unsigned DEFAULT_DATA_BASE = 512;

endpackage

// File: rtl/segmented_memory_arbiter_if.sv
// Bundle of the fetch port, data port and SegmentedMemory port seen by the arbiter.
interface segmented_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out, mem_valid,
    output if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
           mem_address, mem_data_in, mem_read, mem_write
  );

  // Pipeline stages plus memory, as seen from outside the arbiter
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out, mem_valid,
    input  if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
           mem_address, mem_data_in, mem_read, mem_write
  );

endinterface

// File: rtl/segmented_memory_arbiter_grant_select.sv
// Winner selection between fetch and data requests, with a saturating
// starvation counter that forces a fetch grant after too many data grants.
module mem_grant_select
  import tessia_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       idle,
  input  logic       take,
  output requester_t winner
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    winner = (if_req && (!dm_req || starved)) ? REQ_IF : REQ_DM;
  end

  always_comb begin
    starve_d = starve_q;
    if (idle && !if_req) begin
      starve_d = '0;
    end else if (take) begin
      if (winner == REQ_IF) begin
        starve_d = '0;
      end else if (!starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/segmented_memory_arbiter.sv
// Shares one SegmentedMemory port between fetch and data stages: one access per
// IDLE visit, segment-map enforcement, timeout detection, registered outputs.
module segmented_memory_arbiter
  import tessia_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DATA_BASE    = DEFAULT_DATA_BASE,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic                      clk,
  input logic                      rst,
  segmented_memory_arbiter_if.slave bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  requester_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_cnt_inc;

  logic              if_ready_q, if_ready_d, if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_ready_q, dm_ready_d, dm_err_q, dm_err_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;

  requester_t        winner;
  logic              grant_take, idle;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_we, illegal;
  logic              resp_valid, resp_err, resp_to_dm;
  logic [DATA_W-1:0] resp_data;

  assign idle = (state_q == IDLE);

  mem_grant_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk   (clk),
    .rst   (rst),
    .if_req(bus.if_req),
    .dm_req(bus.dm_req),
    .idle  (idle),
    .take  (grant_take),
    .winner(winner)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    to_cnt_inc    = to_cnt_q + 1'b1;
    to_cnt_d      = to_cnt_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    grant_take    = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;
    resp_to_dm    = (owner_q == REQ_DM);

    pick_addr = (winner == REQ_IF) ? bus.if_addr : bus.dm_addr;
    pick_we   = (winner == REQ_DM) && bus.dm_we;
    // Fetches must stay in the instruction segment; stores must stay in the data segment.
    illegal   = (winner == REQ_IF) ? (pick_addr >= ADDR_W'(DATA_BASE))
                                   : (pick_we && (pick_addr < ADDR_W'(DATA_BASE)));

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant_take = 1'b1;
          owner_d    = winner;
          addr_d     = pick_addr;
          we_d       = pick_we;
          wdata_d    = (winner == REQ_DM) ? bus.dm_wdata : '0;
          to_cnt_d   = '0;
          if (illegal) begin
            state_d    = RESP;
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            resp_to_dm = (winner == REQ_DM);
          end else begin
            state_d       = BUSY;
            mem_read_d    = !pick_we;
            mem_write_d   = pick_we;
            mem_address_d = pick_addr;
            mem_data_in_d = wdata_d;
          end
        end
      end
      BUSY: begin
        if (bus.mem_valid) begin
          state_d    = RESP;
          resp_valid = 1'b1;
          resp_data  = we_q ? '0 : bus.mem_data_out;
        end else if (to_cnt_inc == TO_W'(TIMEOUT)) begin
          state_d    = RESP;
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end else begin
          to_cnt_d    = to_cnt_inc;
          mem_read_d  = mem_read_q;
          mem_write_d = mem_write_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response registers load on the transition into RESP so the pulse lines up with RESP.
    if_ready_d = resp_valid && !resp_to_dm;
    if_err_d   = resp_valid && !resp_to_dm && resp_err;
    if_rdata_d = (resp_valid && !resp_to_dm) ? resp_data : if_rdata_q;
    dm_ready_d = resp_valid && resp_to_dm;
    dm_err_d   = resp_valid && resp_to_dm && resp_err;
    dm_rdata_d = (resp_valid && resp_to_dm) ? resp_data : dm_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= REQ_IF;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      to_cnt_q      <= '0;
      if_ready_q    <= 1'b0;
      if_err_q      <= 1'b0;
      if_rdata_q    <= '0;
      dm_ready_q    <= 1'b0;
      dm_err_q      <= 1'b0;
      dm_rdata_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      to_cnt_q      <= to_cnt_d;
      if_ready_q    <= if_ready_d;
      if_err_q      <= if_err_d;
      if_rdata_q    <= if_rdata_d;
      dm_ready_q    <= dm_ready_d;
      dm_err_q      <= dm_err_d;
      dm_rdata_q    <= dm_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign bus.if_ready    = if_ready_q;
  assign bus.if_err      = if_err_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_ready    = dm_ready_q;
  assign bus.dm_err      = dm_err_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;

endmodule
